memory_bist: RTL

MEMORY_BIST -- requirements
Module: memory_bist

---
 rtl/memory_bist_pkg.sv | 27 ++
 rtl/memory_bist_if.sv | 22 ++
 rtl/memory_bist.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/memory_bist_pkg.sv
// Shared definitions for the March-style memory self-test engine:
// controller state encoding, default background pattern, error counter
// limits and the last-address helper.
package memory_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } bistState_t;

  // Background pattern; each word is this value XORed with its address.
  localparam logic [31:0] BASE_DEFAULT = 32'hA5A5_A5A5;

  // Error counter width and its saturation value.
  localparam int ERR_W = 10;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Highest address of a memory with addrW address bits.
  function automatic int unsigned lastAddr(input int unsigned addrW);
    return (32'd1 << addrW) - 32'd1;
  endfunction

endpackage

// File: rtl/memory_bist_if.sv
// Memory-side bus between the self-test engine (master) and the memory
// under test (slave). Read_Data is the word stored at MemAddr.
interface memory_bist_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] Write_Data;
  logic [DATA_W-1:0] Read_Data;

  modport master (
    output MemAddr, MemRead, MemWrite, Write_Data,
    input  Read_Data
  );

  modport slave (
    input  MemAddr, MemRead, MemWrite, Write_Data,
    output Read_Data
  );
endinterface

// File: rtl/memory_bist.sv
// Memory self-test controller. Runs an ascending write of P(a), an
// ascending read-P / write-Q pass, and a descending read-Q pass, where
// P(a) = BASE ^ a and Q(a) = ~P(a). Counts mismatches (saturating) and
// captures the address and data of the first one.
module memory_bist
  import memory_bist_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] BASE = DATA_W'(BASE_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  memory_bist_if.master      mem,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [DATA_W-1:0]  fail_data,
  output logic [ERR_W-1:0]   err_count
);

  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(lastAddr(ADDR_W));

  function automatic logic [DATA_W-1:0] patP(input logic [ADDR_W-1:0] a);
    return BASE ^ DATA_W'(a);
  endfunction

  bistState_t        stateReg, stateNext;
  logic [ADDR_W-1:0] addrReg, addrNext;
  logic [ERR_W-1:0]  errReg, errNext;
  logic [ADDR_W-1:0] failAddrReg, failAddrNext;
  logic [DATA_W-1:0] failDataReg, failDataNext;
  logic              mismatch;
  logic              memReadReg, memWriteReg;
  logic [DATA_W-1:0] writeDataReg;
  logic              busyReg, doneReg, passReg;

  // Next-state, address sequencing and read-compare bookkeeping.
  always_comb begin
    stateNext    = stateReg;
    addrNext     = addrReg;
    errNext      = errReg;
    failAddrNext = failAddrReg;
    failDataNext = failDataReg;
    mismatch     = 1'b0;
    case (stateReg)
      IDLE, DONE: begin
        if (start) begin
          stateNext    = WR0;
          addrNext     = '0;
          errNext      = '0;
          failAddrNext = '0;
          failDataNext = '0;
        end
      end
      WR0: begin
        if (addrReg == ADDR_END) begin
          stateNext = RD0;
          addrNext  = '0;
        end else begin
          addrNext = addrReg + ADDR_W'(1);
        end
      end
      RD0: begin
        mismatch  = (mem.Read_Data != patP(addrReg));
        stateNext = WR1;
      end
      WR1: begin
        // The descending pass starts at the last address, which is where we are.
        if (addrReg == ADDR_END) begin
          stateNext = RD1;
        end else begin
          stateNext = RD0;
          addrNext  = addrReg + ADDR_W'(1);
        end
      end
      RD1: begin
        mismatch = (mem.Read_Data != ~patP(addrReg));
        if (addrReg == '0) begin
          stateNext = DONE;
        end else begin
          addrNext = addrReg - ADDR_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
    if (mismatch) begin
      if (errReg != ERR_MAX) begin
        errNext = errReg + ERR_W'(1);
      end
      if (errReg == '0) begin
        failAddrNext = addrReg;
        failDataNext = mem.Read_Data;
      end
    end
  end

  // State, capture registers and registered bus/status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      addrReg      <= '0;
      errReg       <= '0;
      failAddrReg  <= '0;
      failDataReg  <= '0;
      memReadReg   <= 1'b0;
      memWriteReg  <= 1'b0;
      writeDataReg <= '0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      passReg      <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      addrReg      <= addrNext;
      errReg       <= errNext;
      failAddrReg  <= failAddrNext;
      failDataReg  <= failDataNext;
      memReadReg   <= (stateNext == RD0) || (stateNext == RD1);
      memWriteReg  <= (stateNext == WR0) || (stateNext == WR1);
      writeDataReg <= (stateNext == WR0) ? patP(addrNext) :
                      (stateNext == WR1) ? ~patP(addrNext) : '0;
      busyReg      <= (stateNext != IDLE) && (stateNext != DONE);
      doneReg      <= (stateNext == DONE);
      passReg      <= (stateNext == DONE) && (errNext == '0);
    end
  end

  assign mem.MemAddr    = addrReg;
  assign mem.MemRead    = memReadReg;
  assign mem.MemWrite   = memWriteReg;
  assign mem.Write_Data = writeDataReg;
  assign busy           = busyReg;
  assign done           = doneReg;
  assign pass           = passReg;
  assign fail_addr      = failAddrReg;
  assign fail_data      = failDataReg;
  assign err_count      = errReg;

endmodule
